// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU start/done initiator.
// The ALU_FLAGS_REG_EN build option lives in alu_issue.sv; nothing here depends on it.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MODE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        READ,
        RESP
    } state_e;

    localparam logic [7:0] CLR_CMP_INS  = 8'h40;
    localparam logic [7:0] CMP_OFF_INS  = 8'h41;
    localparam logic [7:0] CMP_ON_INS   = 8'h42;
    localparam logic [7:0] SIGN_OFF_INS = 8'h43;
    localparam logic [7:0] SIGN_ON_INS  = 8'h44;

    // Mode opcodes only reconfigure the ALU; they never use start/done.
    function automatic logic is_mode_op(input logic [7:0] cins);
        return (cins >= CLR_CMP_INS) && (cins <= SIGN_ON_INS);
    endfunction

endpackage

// File: rtl/alu_issue_timer.sv
// Timeout counter for the two done-wait states; expired_o flags the last allowed wait cycle.
module alu_issue_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count starts at zero on the first wait cycle, so TIMEOUT-1 is the final cycle.
    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_issue.sv
// Initiator for the ALU start/done protocol with a valid/ready request and response port.
// Build option ALU_FLAGS_REG_EN adds a {C,V,Z,N} flag register and the flags_q port.
module alu_issue
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cins,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_over,
    output logic       rsp_err,
    output logic       alu_start,
    output logic [7:0] alu_cins,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_carryin,
    output logic       alu_oe,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic       alu_carryout,
    input  logic       alu_overout
`ifdef ALU_FLAGS_REG_EN
    ,
    output logic [3:0] flags_q
`endif
);

    state_e     state_q, state_d;
    logic [7:0] cins_q, cins_d, a_q, a_d, b_q, b_d;
    logic       carry_q, carry_d;
    logic [7:0] rspData_q, rspData_d;
    logic       rspCarry_q, rspCarry_d, rspOver_q, rspOver_d, rspErr_q, rspErr_d;
    logic       timerClear, timerEn, timerExpired, active, useCarry;

    alu_issue_timer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timerClear),
        .en_i     (timerEn),
        .expired_o(timerExpired)
    );

    always_comb begin
        state_d    = state_q;
        cins_d     = cins_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        rspData_d  = rspData_q;
        rspCarry_d = rspCarry_q;
        rspOver_d  = rspOver_q;
        rspErr_d   = rspErr_q;
        timerClear = 1'b0;
        timerEn    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cins_d  = req_cins;
                    a_d     = req_a;
                    b_d     = req_b;
                    carry_d = req_carry;
                    state_d = is_mode_op(req_cins) ? MODE : ISSUE;
                end
            end
            MODE: begin
                rspData_d  = '0;
                rspCarry_d = 1'b0;
                rspOver_d  = 1'b0;
                rspErr_d   = 1'b0;
                state_d    = RESP;
            end
            ISSUE: begin
                timerClear = 1'b1;
                state_d    = WAIT_LO;
            end
            // A done level that is already low here also covers an ALU that was busy at ISSUE.
            WAIT_LO, WAIT_HI: begin
                if ((state_q == WAIT_LO) ? !alu_done : alu_done) begin
                    timerClear = 1'b1;
                    state_d    = (state_q == WAIT_LO) ? WAIT_HI : READ;
                end else if (timerExpired) begin
                    rspData_d  = '0;
                    rspCarry_d = 1'b0;
                    rspOver_d  = 1'b0;
                    rspErr_d   = 1'b1;
                    state_d    = RESP;
                end else begin
                    timerEn = 1'b1;
                end
            end
            READ: begin
                rspData_d  = alu_result;
                rspCarry_d = alu_carryout;
                rspOver_d  = alu_overout;
                rspErr_d   = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cins_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            rspData_q  <= '0;
            rspCarry_q <= 1'b0;
            rspOver_q  <= 1'b0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cins_q     <= cins_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            rspData_q  <= rspData_d;
            rspCarry_q <= rspCarry_d;
            rspOver_q  <= rspOver_d;
            rspErr_q   <= rspErr_d;
        end
    end

`ifdef ALU_FLAGS_REG_EN
    logic [3:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (state_q == READ) begin
            flags_d = {alu_carryout, alu_overout, (alu_result == 8'h00), alu_result[7]};
        end else if (((state_q == WAIT_LO) || (state_q == WAIT_HI)) && (state_d == RESP)) begin
            flags_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // The latched request carry selects the stored C flag instead of supplying the value.
    assign useCarry = carry_q & flags_q[3];
`else
    assign useCarry = carry_q;
`endif

    assign active      = (state_q inside {MODE, ISSUE, WAIT_LO, WAIT_HI, READ});
    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_data    = rsp_valid ? rspData_q : 8'h00;
    assign rsp_carry   = rsp_valid & rspCarry_q;
    assign rsp_over    = rsp_valid & rspOver_q;
    assign rsp_err     = rsp_valid & rspErr_q;
    assign alu_start   = (state_q == ISSUE);
    assign alu_oe      = (state_q == READ);
    assign alu_cins    = active ? cins_q : 8'h00;
    assign alu_a       = active ? a_q : 8'h00;
    assign alu_b       = active ? b_q : 8'h00;
    assign alu_carryin = active & useCarry;

endmodule
